roc_burst_reader: RTL
=====================

# roc_burst_reader

Burst read-back engine for the `roc` register-file memory (8-bit data, 4-bit address, 16 entries). On a start command it reads `len+1` consecutive locations from a base address, wrapping past 15 back to 0. Each word is presented on a valid/ready stream output, and an XOR checksum of the burst is produced. It sits on the read side of `roc`, driving its `addr` port and consuming its `data_out`, while the write side (`wr`/`data`) stays with the loading logic.

## Interface
- `DW`, 8, data width; matches `roc` data.
- `AW`, 4, address width; also the width of `len`.
- `DEP`, 16, memory depth, 2**AW; addresses wrap modulo `DEP`.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  AW  first address of the burst; latched with `start`.
- `len`  in  AW  word count minus one (0 means 1 word, 15 means 16 words); latched with `start`.
- `abort`  in  1  terminates a burst in progress.
- `mem_addr`  out  AW  address to `roc.addr`; registered.
- `mem_rdata`  in  DW  from `roc.data_out`; valid one cycle after `mem_addr` changes.
- `out_data`  out  DW  stream data; registered.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from the consumer.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `checksum`  out  DW  XOR of all accepted words; held until the next `start`.

## Operation
- States are IDLE, ISSUE, CAPT, PRES and DONE.
- **IDLE**
  - With `start`=1: latch `addr_r`=`base_addr` and `cnt`=`len`, clear `checksum`, go to ISSUE.
  - With `start`=0: stay in IDLE.
- **ISSUE**: `mem_addr` is driven from `addr_r`. Go to CAPT.
- **CAPT**: `out_data` <= `mem_rdata`. Go to PRES.
- **PRES**
  - `out_valid`=1. `out_data` stays stable until the handshake.
  - On `out_ready`=1: `checksum` <= `checksum` ^ `out_data`.
    - If `cnt`==0, go to DONE.
    - Otherwise `cnt`--, `addr_r` <= (`addr_r`+1) mod `DEP`, go to ISSUE.
  - On `out_ready`=0: stay in PRES.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- `abort`
  - In ISSUE, CAPT or PRES: next state is IDLE.
  - No `done` pulse is produced. `checksum` keeps its partial value. `out_valid` drops on the next edge.
  - In IDLE or DONE: ignored.
- `start` is ignored while `busy`=1.
- `start` and `abort` in the same IDLE cycle: `start` wins.
- `abort` and a handshake in the same PRES cycle: the word counts as accepted (`checksum` is updated), then the block goes to IDLE with no `done` pulse.
- Address arithmetic is AW-bit unsigned, so 15+1 = 0 and the burst wraps.
- The block never drives the memory write port.

## Timing
- **Reset values**: state IDLE, `mem_addr`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `checksum`=0, internal `cnt`=0, `addr_r`=0.
- **Reset mid-burst**: all of the above takes effect immediately and asynchronously. No `done` pulse follows.
- **Start to first word**: `start` sampled at edge k gives ISSUE in cycle k+1, CAPT in k+2, and `out_valid`=1 from cycle k+3.
- **Throughput**: with `out_ready` held high, word i (0-based) is valid in cycle k+3+3i. `done` is high in cycle k+3N+1, where N=`len`+1.
- **Backpressure**: each cycle `out_ready`=0 in PRES adds exactly one cycle and changes nothing else.
- **`busy` pulse**: high from cycle k+1 through the DONE cycle, inclusive.
- **Back-to-back commands**: a new `start` is accepted in the first IDLE cycle after DONE.

## Test plan
- **Reset**
  - Stimulus: `rst`=1 with random inputs.
  - Required: all outputs 0, `busy`=0. Assert `rst` mid-PRES and confirm `out_valid` drops asynchronously and no `done` pulse follows.
- **Single word**
  - Stimulus: preload mem[8]=8'h51. Start with `base_addr`=8, `len`=0, `out_ready`=1.
  - Required: `out_data`=8'h51 with `out_valid` in cycle k+3, `done` in k+4, `checksum`=8'h51.
- **Burst**
  - Stimulus: preload mem[i]=8'h10+i. Start with `base_addr`=8, `len`=2.
  - Required: stream 8'h18, 8'h19, 8'h1A at cycles k+3, k+6, k+9. `done` at k+10. `checksum`=8'h1B.
- **Wrap**
  - Stimulus: same preload, `base_addr`=14, `len`=3.
  - Required: `mem_addr` sequence 14, 15, 0, 1. Data 8'h1E, 8'h1F, 8'h10, 8'h11. `checksum`=8'h00.
- **Backpressure and ignored start**
  - Stimulus: `out_ready`=0 for 5 cycles on the second word; pulse `start` with `base_addr`=0 while busy.
  - Required: `out_data` stable throughout the stall. Words and `checksum` are unchanged versus the unstalled run. The in-flight burst is unaffected.
- **Abort**
  - Stimulus: `abort` in CAPT of the second word of a 4-word burst.
  - Required: IDLE next cycle, no `done` pulse, `checksum` equals the first word only. A following `start` runs normally.

Source files
------------

// File: rtl/roc_burst_reader.sv
`default_nettype none
// ============================================================================
// roc_burst_reader : burst read-back of the roc register file, XOR checksum
// Revision 1.0
// ============================================================================
module roc_burst_reader #(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int DEP = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] len,
  input  logic          abort,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAPT  = 3'd2,
    PRES  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] cnt;
  logic [AW-1:0] addr_inc;
  logic          load;
  logic          accept;
  logic          advance;

  assign addr_inc = (addr_r == AW'(DEP - 1)) ? '0 : addr_r + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    out_valid = (state == PRES);
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = abort ? IDLE : CAPT;
      CAPT:  state_nxt = abort ? IDLE : PRES;
      PRES: begin
        // A handshake coinciding with abort still counts the word.
        if (out_ready) begin
          accept = 1'b1;
          if (abort) begin
            state_nxt = IDLE;
          end else if (cnt == '0) begin
            state_nxt = DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = ISSUE;
          end
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr is loaded together with addr_r so the synchronous roc read
  // completes during ISSUE and mem_rdata is ready to capture in CAPT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r   <= '0;
      cnt      <= '0;
      mem_addr <= '0;
      out_data <= '0;
      checksum <= '0;
    end else begin
      if (load) begin
        addr_r   <= base_addr;
        mem_addr <= base_addr;
        cnt      <= len;
        checksum <= '0;
      end
      if (advance) begin
        addr_r   <= addr_inc;
        mem_addr <= addr_inc;
        cnt      <= cnt - 1'b1;
      end
      if (state == CAPT) out_data <= mem_rdata;
      if (accept)        checksum <= checksum ^ out_data;
    end
  end

endmodule
`default_nettype wire
